// File: rtl/compl1_checker.sv
// compl1_checker: sweeps every (inp, cpl) vector into a one's-complement unit and checks its output.
// Latency: SETTLE+2 cycles per vector, 2^(WIDTH+1)*(SETTLE+2) cycles per sweep; done rises one edge after the last check.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while a sweep is running.
module compl1_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_inp,
    output logic               dut_cpl,
    input  logic [WIDTH-1:0]   dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH+1:0]   err_count,
    output logic [WIDTH:0]     first_fail_vec
);

    // Settle counter only needs to hold SETTLE-1; keep at least one bit so SETTLE=1 still elaborates.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [WIDTH:0]   LAST_VEC    = '1;
    localparam logic [WIDTH:0]   VEC_ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH+1:0] ERR_ONE     = (WIDTH+2)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   vec;
    logic [CW-1:0]    settle_cnt;
    logic [WIDTH-1:0] decoded;
    logic             mismatch;

    // Undo the complement the unit was asked to apply; a healthy unit gives back the applied input.
    assign decoded  = dut_out ^ {WIDTH{dut_cpl}};
    assign mismatch = (decoded != dut_inp);

    // Sweep sequencer: all outputs are registered here so the unit under check sees glitch-free stimulus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            vec            <= '0;
            settle_cnt     <= '0;
            dut_inp        <= '0;
            dut_cpl        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                // IDLE and DONE behave identically on start; results of the previous sweep are discarded.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_DRIVE;
                        vec            <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end

                // Present the vector: upper bits are the data, LSB is the complement control.
                S_DRIVE: begin
                    dut_inp    <= vec[WIDTH:1];
                    dut_cpl    <= vec[0];
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end

                // Give the unit SETTLE cycles before its output is trusted.
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_ONE;
                    end
                end

                // Score this vector, then either advance or close the sweep.
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (err_count == '0) begin
                            first_fail_vec <= vec;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_count == '0) && !mismatch;
                        dut_inp <= '0;
                        dut_cpl <= 1'b0;
                    end else begin
                        vec   <= vec + VEC_ONE;
                        state <= S_DRIVE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    dut_inp <= '0;
                    dut_cpl <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compl1_checker.sv
// tb_compl1_checker: drives two checker instances (SETTLE=2 and SETTLE=1) against behavioural compl1 models.
// Latency: sweeps are timed in cycles from the start edge and compared to (SETTLE+2)*32.
// Backpressure: not applicable; start/reset are pulsed directly from the stimulus sequence.
module tb_compl1_checker;

    logic       clk;
    logic       rst    [2];
    logic       start  [2];
    logic [3:0] d_inp  [2];
    logic       d_cpl  [2];
    logic [3:0] d_out  [2];
    logic       busy   [2];
    logic       done   [2];
    logic       pass   [2];
    logic [5:0] errc   [2];
    logic [4:0] ffv    [2];

    // Model selection per unit: 0 ideal, 1 ignores cpl, 2 out[0] stuck at 0, 3 random per-vector bit flips.
    int         mode   [2];
    logic [3:0] flip   [2][32];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input int m, input logic [3:0] inp, input logic cpl,
                                         input logic [3:0] fl);
        logic [3:0] ideal;
        ideal = cpl ? ~inp : inp;
        case (m)
            1:       return inp;
            2:       return ideal & 4'b1110;
            3:       return ideal ^ fl;
            default: return ideal;
        endcase
    endfunction

    assign d_out[0] = model(mode[0], d_inp[0], d_cpl[0], flip[0][{d_inp[0], d_cpl[0]}]);
    assign d_out[1] = model(mode[1], d_inp[1], d_cpl[1], flip[1][{d_inp[1], d_cpl[1]}]);

    compl1_checker #(.WIDTH(4), .SETTLE(2)) u_chk0 (
        .clk(clk), .reset(rst[0]), .start(start[0]),
        .dut_inp(d_inp[0]), .dut_cpl(d_cpl[0]), .dut_out(d_out[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_fail_vec(ffv[0])
    );

    compl1_checker #(.WIDTH(4), .SETTLE(1)) u_chk1 (
        .clk(clk), .reset(rst[1]), .start(start[1]),
        .dut_inp(d_inp[1]), .dut_cpl(d_cpl[1]), .dut_out(d_out[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_fail_vec(ffv[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk all 32 vectors, count those whose model output differs from the ideal complement.
    task automatic expect_for(input int u, output int e, output int f);
        logic [4:0] vv;
        logic [3:0] ideal;
        e = 0;
        f = 0;
        for (int v = 0; v < 32; v++) begin
            vv    = 5'(v);
            ideal = vv[0] ? ~vv[4:1] : vv[4:1];
            if (model(mode[u], vv[4:1], vv[0], flip[u][v]) !== ideal) begin
                if (e == 0) f = v;
                e++;
            end
        end
    endtask

    task automatic chk_idle_outputs(input int u, input string tag);
        chk({tag, "_inp"},  32'(d_inp[u]), 0);
        chk({tag, "_cpl"},  32'(d_cpl[u]), 0);
        chk({tag, "_busy"}, 32'(busy[u]),  0);
        chk({tag, "_done"}, 32'(done[u]),  0);
        chk({tag, "_pass"}, 32'(pass[u]),  0);
        chk({tag, "_errc"}, 32'(errc[u]),  0);
        chk({tag, "_ffv"},  32'(ffv[u]),   0);
    endtask

    // One sweep: pulses start, follows busy, checks the applied vector each cycle against the cycle count.
    task automatic sweep(input int u, input int restart_at, input int reset_at,
                         output int cycles, output bit order_ok, output bit was_reset);
        int sp;
        int expv;
        sp        = (u == 0) ? 2 : 1;
        order_ok  = 1'b1;
        was_reset = 1'b0;
        @(negedge clk) start[u] = 1'b1;
        @(negedge clk) start[u] = 1'b0;
        cycles = 0;
        while (busy[u] === 1'b1 && cycles < 400) begin
            expv = (cycles == 0) ? 0 : (cycles - 1) / (sp + 2);
            if ({d_inp[u], d_cpl[u]} !== 5'(expv)) order_ok = 1'b0;
            if (cycles == restart_at) start[u] = 1'b1;
            if (cycles == reset_at)   rst[u]   = 1'b1;
            @(negedge clk);
            start[u] = 1'b0;
            if (rst[u]) begin
                rst[u]    = 1'b0;
                was_reset = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic full_check(input int u, input string tag, input int exp_cycles,
                              input int restart_at);
        int  cyc, e, f;
        bit  ok, rs;
        expect_for(u, e, f);
        sweep(u, restart_at, -1, cyc, ok, rs);
        chk({tag, "_cycles"}, cyc, exp_cycles);
        chk({tag, "_order"},  32'(ok), 1);
        chk({tag, "_done"},   32'(done[u]), 1);
        chk({tag, "_pass"},   32'(pass[u]), (e == 0) ? 1 : 0);
        chk({tag, "_errc"},   32'(errc[u]), e);
        if (e != 0) chk({tag, "_ffv"}, 32'(ffv[u]), f);
        chk({tag, "_inp_done"}, {27'd0, d_inp[u], d_cpl[u]}, 0);
    endtask

    initial begin
        int  cyc;
        bit  ok, rs;
        n_cmp = 0;
        n_err = 0;
        for (int u = 0; u < 2; u++) begin
            rst[u]   = 1'b1;
            start[u] = 1'b0;
            mode[u]  = 0;
            for (int i = 0; i < 32; i++) flip[u][i] = 4'd0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk_idle_outputs(0, "rst0");
        chk_idle_outputs(1, "rst1");

        // Reset and start together: reset must win.
        @(negedge clk);
        rst[0]   = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        rst[0]   = 1'b0;
        start[0] = 1'b0;
        chk("rst_start_busy", 32'(busy[0]), 0);
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy[0]), 0);

        // Ideal unit, default settle.
        full_check(0, "ideal", 128, -1);

        // cpl ignored: every complemented vector fails.
        mode[0] = 1;
        full_check(0, "nocpl", 128, -1);
        chk("nocpl_errc16", 32'(errc[0]), 16);
        chk("nocpl_ffv1",   32'(ffv[0]),  1);

        // out[0] stuck at 0.
        mode[0] = 2;
        full_check(0, "stuck0", 128, -1);
        chk("stuck0_errc16", 32'(errc[0]), 16);
        chk("stuck0_ffv1",   32'(ffv[0]),  1);

        // start during vector 5 is ignored.
        mode[0] = 1;
        full_check(0, "restart", 128, 22);

        // Reset during vector 10 discards everything.
        mode[0] = 0;
        sweep(0, -1, 42, cyc, ok, rs);
        chk("midreset_seen", 32'(rs), 1);
        chk_idle_outputs(0, "midreset");
        full_check(0, "after_reset", 128, -1);

        // SETTLE=1 instance: failing sweep, then restart from DONE with the ideal model.
        mode[1] = 1;
        full_check(1, "s1_fail", 96, -1);
        mode[1] = 0;
        @(negedge clk) start[1] = 1'b1;
        @(negedge clk) start[1] = 1'b0;
        chk("s1_restart_done_clr", 32'(done[1]), 0);
        chk("s1_restart_errc_clr", 32'(errc[1]), 0);
        chk("s1_restart_busy",     32'(busy[1]), 1);
        while (busy[1] === 1'b1) @(negedge clk);
        full_check(1, "s1_ideal", 96, -1);

        // Randomised fault tables against the reference walk.
        mode[0] = 3;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 32; i++)
                flip[0][i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            full_check(0, $sformatf("rand%0d", r), 128, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
